bus85_mem: RTL and testbench

- Memory slave on the core85 multiplexed system bus. It sits directly downstream of the processor's AD/A/ALE/RD_/WR_/IO-M_ pins.
- Demultiplexes and latches the address on ALE, decodes the memory window, and inserts a programmable number of wait states via READY.
- Serves byte reads and writes from internal RAM. Replaces the behavioural memory array used around the core today with synthesizable RTL.

---
 rtl/bus85_mem.sv | 224 ++++++++++++++++++++++
 tb/tb_bus85_mem.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus85_mem.sv
// bus85_mem: byte-wide RAM slave on the core85 multiplexed system bus.
// Latches the address on ALE, decodes the RAM window (and, optionally, one IO
// port), inserts WAITS wait states by pulling READY low, then serves one byte
// read or write per bus cycle.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous reset, active-high
//   ad_in     low address during ALE, write data afterwards
//   a_hi      upper address pins
//   ale       address latch enable, active-high
//   rd_, wr_  read / write strobes, active-low
//   iom_      0 = memory cycle, 1 = IO cycle
//   ad_out    read data for the AD bus
//   ad_oe     AD bus drive enable (tristate control at the top level)
//   ready     to core READY; low inserts wait states
//   port_in   (BUS85MEM_IOPORT_EN only) value returned by an IO read
//   port_out  (BUS85MEM_IOPORT_EN only) register loaded by an IO write
//
// Build option: define BUS85MEM_IOPORT_EN to add the IO port at IOADDR.
// Without it every IO cycle is treated as a miss.

module bus85_mem #(
  parameter int unsigned          DATASIZE = 8,
  parameter int unsigned          ADDRSIZE = 16,
  parameter int unsigned          MEMBITS  = 12,
  parameter logic [ADDRSIZE-1:0]  BASEADDR = '0,
  parameter int unsigned          WAITS    = 0
`ifdef BUS85MEM_IOPORT_EN
  ,
  parameter logic [DATASIZE-1:0]  IOADDR   = DATASIZE'(8'h10)
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATASIZE-1:0]          ad_in,
  input  logic [ADDRSIZE-DATASIZE-1:0] a_hi,
  input  logic                         ale,
  input  logic                         rd_,
  input  logic                         wr_,
  input  logic                         iom_,
  output logic [DATASIZE-1:0]          ad_out,
  output logic                         ad_oe,
  output logic                         ready
`ifdef BUS85MEM_IOPORT_EN
  ,
  input  logic [DATASIZE-1:0]          port_in,
  output logic [DATASIZE-1:0]          port_out
`endif
);

  localparam int unsigned MEMDEPTH = 1 << MEMBITS;
  localparam int unsigned WCW      = 4;

  // Only address bits above the RAM index take part in the window compare.
  localparam logic [ADDRSIZE-1:0] WIN_MASK = {ADDRSIZE{1'b1}} << MEMBITS;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ADDR   = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_ACCESS = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;

  logic [2:0]          state, state_nxt;
  logic [ADDRSIZE-1:0] addr, addr_nxt;
  logic                dir_rd, dir_rd_nxt;
  logic                is_io, is_io_nxt;
  logic [WCW-1:0]      wcnt, wcnt_nxt;
  logic                ready_nxt;
  logic                oe_nxt;

  logic                mem_hit_c;
  logic                io_hit_c;
  logic                rd_go_c;
  logic                wr_go_c;

  logic [DATASIZE-1:0] mem [MEMDEPTH];

  // Address decode against the latched address; iom_ is sampled with the strobe.
  assign mem_hit_c = !iom_ && ((addr & WIN_MASK) == (BASEADDR & WIN_MASK));
`ifdef BUS85MEM_IOPORT_EN
  assign io_hit_c  = iom_ && (addr[DATASIZE-1:0] == IOADDR);
`else
  assign io_hit_c  = 1'b0;
`endif

  // Next-state and next-output logic; ALE overrides every state.
  always_comb begin
    state_nxt  = state;
    addr_nxt   = addr;
    dir_rd_nxt = dir_rd;
    is_io_nxt  = is_io;
    wcnt_nxt   = wcnt;
    ready_nxt  = ready;
    oe_nxt     = ad_oe;
    rd_go_c    = 1'b0;
    wr_go_c    = 1'b0;

    if (ale) begin
      addr_nxt  = {a_hi, ad_in};
      oe_nxt    = 1'b0;
      ready_nxt = 1'b1;
      state_nxt = ST_ADDR;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_IDLE;
        end

        ST_ADDR: begin
          if (!rd_ && !wr_) begin
            // Both strobes low is illegal: wait here for a sane cycle.
            state_nxt = ST_ADDR;
          end else if (!rd_ || !wr_) begin
            if (mem_hit_c || io_hit_c) begin
              dir_rd_nxt = !rd_;
              is_io_nxt  = iom_;
              if (WAITS == 0) begin
                state_nxt = ST_ACCESS;
              end else begin
                wcnt_nxt  = WCW'(WAITS);
                ready_nxt = 1'b0;
                state_nxt = ST_WAIT;
              end
            end else begin
              state_nxt = ST_HOLD;
            end
          end
        end

        ST_WAIT: begin
          if (rd_ && wr_) begin
            // Master gave up the cycle: drop it without touching RAM.
            wcnt_nxt  = '0;
            ready_nxt = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            wcnt_nxt = wcnt - WCW'(1);
            if (wcnt == WCW'(1)) begin
              ready_nxt = 1'b1;
              state_nxt = ST_ACCESS;
            end
          end
        end

        ST_ACCESS: begin
          if (dir_rd) begin
            rd_go_c = 1'b1;
            oe_nxt  = 1'b1;
          end else begin
            wr_go_c = 1'b1;
          end
          state_nxt = ST_HOLD;
        end

        ST_HOLD: begin
          if (rd_ && wr_) begin
            oe_nxt    = 1'b0;
            state_nxt = ST_IDLE;
          end
        end

        default: begin
          ready_nxt = 1'b1;
          oe_nxt    = 1'b0;
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State and control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      addr   <= '0;
      dir_rd <= 1'b0;
      is_io  <= 1'b0;
      wcnt   <= '0;
      ready  <= 1'b1;
      ad_oe  <= 1'b0;
    end else begin
      state  <= state_nxt;
      addr   <= addr_nxt;
      dir_rd <= dir_rd_nxt;
      is_io  <= is_io_nxt;
      wcnt   <= wcnt_nxt;
      ready  <= ready_nxt;
      ad_oe  <= oe_nxt;
    end
  end

  // RAM write port; contents survive reset, but reset blocks a pending write.
  always_ff @(posedge clk) begin
    if (!rst && wr_go_c && !is_io) begin
      mem[addr[MEMBITS-1:0]] <= ad_in;
    end
  end

  // Read data register driven onto the AD bus while ad_oe is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      ad_out <= '0;
    end else if (rd_go_c) begin
`ifdef BUS85MEM_IOPORT_EN
      ad_out <= is_io ? port_in : mem[addr[MEMBITS-1:0]];
`else
      ad_out <= mem[addr[MEMBITS-1:0]];
`endif
    end
  end

`ifdef BUS85MEM_IOPORT_EN
  // Output port register loaded by an IO write hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      port_out <= '0;
    end else if (wr_go_c && is_io) begin
      port_out <= ad_in;
    end
  end
`endif

endmodule

// File: tb/tb_bus85_mem.sv
// Bench for bus85_mem: two instances share the bus (WAITS=0 and WAITS=3);
// each is addressed by gating ALE. Read data is checked through a queue of
// expected bytes derived from a per-instance RAM model.

module tb_bus85_mem;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ad_in;
  logic [7:0] a_hi;
  logic       ale;
  logic       rd_;
  logic       wr_;
  logic       iom_;
  int         sel;

  logic       ale0, ale3;
  logic [7:0] ad_out0, ad_out3;
  logic       ad_oe0, ad_oe3;
  logic       ready0, ready3;
`ifdef BUS85MEM_IOPORT_EN
  logic [7:0] port_in;
  logic [7:0] port_out0, port_out3;
`endif

  logic [7:0] model [2][4096];
  logic [7:0] exp_q [$];
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  assign ale0 = ale && (sel == 0);
  assign ale3 = ale && (sel == 1);

  bus85_mem #(.DATASIZE(8), .ADDRSIZE(16), .MEMBITS(12), .BASEADDR(16'h0000), .WAITS(0)) u_dut0 (
    .clk(clk), .rst(rst), .ad_in(ad_in), .a_hi(a_hi), .ale(ale0), .rd_(rd_), .wr_(wr_),
    .iom_(iom_), .ad_out(ad_out0), .ad_oe(ad_oe0), .ready(ready0)
`ifdef BUS85MEM_IOPORT_EN
    , .port_in(port_in), .port_out(port_out0)
`endif
  );

  bus85_mem #(.DATASIZE(8), .ADDRSIZE(16), .MEMBITS(12), .BASEADDR(16'h0000), .WAITS(3)) u_dut3 (
    .clk(clk), .rst(rst), .ad_in(ad_in), .a_hi(a_hi), .ale(ale3), .rd_(rd_), .wr_(wr_),
    .iom_(iom_), .ad_out(ad_out3), .ad_oe(ad_oe3), .ready(ready3)
`ifdef BUS85MEM_IOPORT_EN
    , .port_in(port_in), .port_out(port_out3)
`endif
  );

  function automatic logic get_oe(input int d);
    return (d == 0) ? ad_oe0 : ad_oe3;
  endfunction

  function automatic logic get_rdy(input int d);
    return (d == 0) ? ready0 : ready3;
  endfunction

  function automatic logic [7:0] get_dout(input int d);
    return (d == 0) ? ad_out0 : ad_out3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete bus cycle; returns what was observed, checks nothing.
  task automatic bus_access(input int d, input logic [15:0] a, input logic is_rd,
                            input logic io, input logic [7:0] wd,
                            output int rdy_low, output int oe_edge,
                            output logic [7:0] rdata, output logic oe_last,
                            output logic oe_rel);
    sel  = d;
    ale  = 1'b1;
    a_hi = a[15:8];
    ad_in = a[7:0];
    iom_ = io;
    rd_  = 1'b1;
    wr_  = 1'b1;
    tick();
    ale   = 1'b0;
    ad_in = is_rd ? 8'h00 : wd;
    if (is_rd) rd_ = 1'b0;
    else       wr_ = 1'b0;
    rdy_low = 0;
    oe_edge = 0;
    rdata   = 8'h00;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (!get_rdy(d)) rdy_low++;
      if (get_oe(d) && oe_edge == 0) begin
        oe_edge = k;
        rdata   = get_dout(d);
      end
    end
    oe_last = get_oe(d);
    rd_ = 1'b1;
    wr_ = 1'b1;
    tick();
    oe_rel = get_oe(d);
    iom_ = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; ale = 1'b0; rd_ = 1'b1; wr_ = 1'b1; iom_ = 1'b0;
    ad_in = 8'h00; a_hi = 8'h00; sel = 0;
`ifdef BUS85MEM_IOPORT_EN
    port_in = 8'h00;
`endif
    tick(); tick();
    for (int d = 0; d < 2; d++) begin
      n_vec++; if (get_rdy(d) !== 1'b1) begin n_err++; $display("FAIL reset_ready dut%0d: got %b want 1", d, get_rdy(d)); end
      n_vec++; if (get_oe(d) !== 1'b0) begin n_err++; $display("FAIL reset_oe dut%0d: got %b want 0", d, get_oe(d)); end
      n_vec++; if (get_dout(d) !== 8'h00) begin n_err++; $display("FAIL reset_dout dut%0d: got %h want 00", d, get_dout(d)); end
    end
`ifdef BUS85MEM_IOPORT_EN
    n_vec++; if (port_out0 !== 8'h00) begin n_err++; $display("FAIL reset_port_out: got %h want 00", port_out0); end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read_nowait();
    int rl, oe_e; logic [7:0] rdv, ev; logic ol, orl;
    bus_access(0, 16'h0005, 1'b0, 1'b0, 8'h3E, rl, oe_e, rdv, ol, orl);
    model[0][12'h005] = 8'h3E;
    n_vec++; if (oe_e !== 0) begin n_err++; $display("FAIL w0_write_oe: got edge %0d want none", oe_e); end
    exp_q.push_back(model[0][12'h005]);
    bus_access(0, 16'h0005, 1'b1, 1'b0, 8'h00, rl, oe_e, rdv, ol, orl);
    ev = exp_q.pop_front();
    n_vec++; if (oe_e !== 2) begin n_err++; $display("FAIL w0_read_latency: got %0d want 2", oe_e); end
    n_vec++; if (rdv !== ev) begin n_err++; $display("FAIL w0_read_data: got %h want %h", rdv, ev); end
    n_vec++; if (rl !== 0) begin n_err++; $display("FAIL w0_ready_low: got %0d want 0", rl); end
    n_vec++; if (ol !== 1'b1) begin n_err++; $display("FAIL w0_oe_hold: got %b want 1", ol); end
    n_vec++; if (orl !== 1'b0) begin n_err++; $display("FAIL w0_oe_release: got %b want 0", orl); end
  endtask

  task automatic test_waits3();
    int rl, oe_e; logic [7:0] rdv, ev; logic ol, orl;
    bus_access(1, 16'h0100, 1'b0, 1'b0, 8'hA5, rl, oe_e, rdv, ol, orl);
    model[1][12'h100] = 8'hA5;
    n_vec++; if (rl !== 3) begin n_err++; $display("FAIL w3_write_ready_low: got %0d want 3", rl); end
    n_vec++; if (oe_e !== 0) begin n_err++; $display("FAIL w3_write_oe: got edge %0d want none", oe_e); end
    exp_q.push_back(model[1][12'h100]);
    bus_access(1, 16'h0100, 1'b1, 1'b0, 8'h00, rl, oe_e, rdv, ol, orl);
    ev = exp_q.pop_front();
    n_vec++; if (rl !== 3) begin n_err++; $display("FAIL w3_read_ready_low: got %0d want 3", rl); end
    n_vec++; if (oe_e !== 5) begin n_err++; $display("FAIL w3_read_latency: got %0d want 5", oe_e); end
    n_vec++; if (rdv !== ev) begin n_err++; $display("FAIL w3_read_data: got %h want %h", rdv, ev); end
    n_vec++; if (orl !== 1'b0) begin n_err++; $display("FAIL w3_oe_release: got %b want 0", orl); end
  endtask

  task automatic test_window();
    int rl, oe_e; logic [7:0] rdv, ev; logic ol, orl;
    bus_access(0, 16'h2000, 1'b1, 1'b0, 8'h00, rl, oe_e, rdv, ol, orl);
    n_vec++; if (oe_e !== 0 || rl !== 0) begin n_err++; $display("FAIL miss_2000: got oe edge %0d ready low %0d want 0 0", oe_e, rl); end
    bus_access(0, 16'h1005, 1'b1, 1'b0, 8'h00, rl, oe_e, rdv, ol, orl);
    n_vec++; if (oe_e !== 0) begin n_err++; $display("FAIL miss_1005: got oe edge %0d want none", oe_e); end
    bus_access(1, 16'h8100, 1'b1, 1'b0, 8'h00, rl, oe_e, rdv, ol, orl);
    n_vec++; if (oe_e !== 0 || rl !== 0) begin n_err++; $display("FAIL miss_w3: got oe edge %0d ready low %0d want 0 0", oe_e, rl); end
    bus_access(0, 16'h0000, 1'b0, 1'b0, 8'h5C, rl, oe_e, rdv, ol, orl);
    model[0][12'h000] = 8'h5C;
    bus_access(0, 16'h0FFF, 1'b0, 1'b0, 8'hE1, rl, oe_e, rdv, ol, orl);
    model[0][12'hFFF] = 8'hE1;
    exp_q.push_back(model[0][12'h000]);
    bus_access(0, 16'h0000, 1'b1, 1'b0, 8'h00, rl, oe_e, rdv, ol, orl);
    ev = exp_q.pop_front();
    n_vec++; if (oe_e !== 2 || rdv !== ev) begin n_err++; $display("FAIL read_0000: got edge %0d data %h want 2 %h", oe_e, rdv, ev); end
    exp_q.push_back(model[0][12'hFFF]);
    bus_access(0, 16'h0FFF, 1'b1, 1'b0, 8'h00, rl, oe_e, rdv, ol, orl);
    ev = exp_q.pop_front();
    n_vec++; if (oe_e !== 2 || rdv !== ev) begin n_err++; $display("FAIL read_0fff: got edge %0d data %h want 2 %h", oe_e, rdv, ev); end
  endtask

  task automatic test_abort();
    int rl, oe_e; logic [7:0] rdv, ev; logic ol, orl;
    bus_access(1, 16'h0010, 1'b0, 1'b0, 8'h11, rl, oe_e, rdv, ol, orl);
    model[1][12'h010] = 8'h11;
    sel = 1; ale = 1'b1; a_hi = 8'h00; ad_in = 8'h10; iom_ = 1'b0;
    tick();
    ale = 1'b0; ad_in = 8'h77; wr_ = 1'b0;
    tick();
    n_vec++; if (ready3 !== 1'b0) begin n_err++; $display("FAIL abort_wait_entry: got ready %b want 0", ready3); end
    tick();
    wr_ = 1'b1;
    tick();
    n_vec++; if (ready3 !== 1'b1 || ad_oe3 !== 1'b0) begin n_err++; $display("FAIL abort_release: got ready %b oe %b want 1 0", ready3, ad_oe3); end
    tick(); tick(); tick();
    n_vec++; if (ready3 !== 1'b1) begin n_err++; $display("FAIL abort_idle_ready: got %b want 1", ready3); end
    exp_q.push_back(model[1][12'h010]);
    bus_access(1, 16'h0010, 1'b1, 1'b0, 8'h00, rl, oe_e, rdv, ol, orl);
    ev = exp_q.pop_front();
    n_vec++; if (rdv !== ev || oe_e !== 5) begin n_err++; $display("FAIL abort_no_write: got data %h edge %0d want %h 5", rdv, oe_e, ev); end
  endtask

  task automatic test_reset_mid();
    int rl, oe_e; logic [7:0] rdv, ev; logic ol, orl;
    bus_access(1, 16'h0020, 1'b0, 1'b0, 8'h22, rl, oe_e, rdv, ol, orl);
    model[1][12'h020] = 8'h22;
    sel = 1; ale = 1'b1; a_hi = 8'h00; ad_in = 8'h20; iom_ = 1'b0;
    tick();
    ale = 1'b0; ad_in = 8'h99; wr_ = 1'b0;
    tick();
    n_vec++; if (ready3 !== 1'b0) begin n_err++; $display("FAIL rstmid_wait_entry: got ready %b want 0", ready3); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++; if (ready3 !== 1'b1 || ad_oe3 !== 1'b0) begin n_err++; $display("FAIL rstmid_outputs: got ready %b oe %b want 1 0", ready3, ad_oe3); end
    tick(); tick(); tick(); tick();
    n_vec++; if (ready3 !== 1'b1) begin n_err++; $display("FAIL rstmid_stays_idle: got ready %b want 1", ready3); end
    wr_ = 1'b1;
    tick();
    exp_q.push_back(model[1][12'h020]);
    bus_access(1, 16'h0020, 1'b1, 1'b0, 8'h00, rl, oe_e, rdv, ol, orl);
    ev = exp_q.pop_front();
    n_vec++; if (rdv !== ev) begin n_err++; $display("FAIL rstmid_no_write: got %h want %h", rdv, ev); end
  endtask

  task automatic test_illegal();
    int rl, oe_e, bad; logic [7:0] rdv, ev; logic ol, orl;
    sel = 0; ale = 1'b1; a_hi = 8'h00; ad_in = 8'h05; iom_ = 1'b0;
    tick();
    ale = 1'b0; ad_in = 8'hEE; rd_ = 1'b0; wr_ = 1'b0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (ad_oe0 !== 1'b0 || ready0 !== 1'b1) bad++;
    end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL illegal_no_access: got %0d bad cycles want 0", bad); end
    rd_ = 1'b1; wr_ = 1'b1;
    tick();
    exp_q.push_back(model[0][12'h005]);
    bus_access(0, 16'h0005, 1'b1, 1'b0, 8'h00, rl, oe_e, rdv, ol, orl);
    ev = exp_q.pop_front();
    n_vec++; if (rdv !== ev || oe_e !== 2) begin n_err++; $display("FAIL illegal_ram_intact: got %h edge %0d want %h 2", rdv, oe_e, ev); end
  endtask

  task automatic test_io();
    int rl, oe_e; logic [7:0] rdv, ev; logic ol, orl;
`ifdef BUS85MEM_IOPORT_EN
    bus_access(0, 16'h0010, 1'b0, 1'b0, 8'h33, rl, oe_e, rdv, ol, orl);
    model[0][12'h010] = 8'h33;
    bus_access(0, 16'h0010, 1'b0, 1'b1, 8'h5A, rl, oe_e, rdv, ol, orl);
    n_vec++; if (port_out0 !== 8'h5A) begin n_err++; $display("FAIL io_write: got %h want 5A", port_out0); end
    port_in = 8'hC3;
    exp_q.push_back(port_in);
    bus_access(0, 16'h0010, 1'b1, 1'b1, 8'h00, rl, oe_e, rdv, ol, orl);
    ev = exp_q.pop_front();
    n_vec++; if (rdv !== ev || oe_e !== 2) begin n_err++; $display("FAIL io_read: got %h edge %0d want %h 2", rdv, oe_e, ev); end
    bus_access(0, 16'h0011, 1'b1, 1'b1, 8'h00, rl, oe_e, rdv, ol, orl);
    n_vec++; if (oe_e !== 0 || rl !== 0) begin n_err++; $display("FAIL io_miss_read: got edge %0d ready low %0d want 0 0", oe_e, rl); end
    bus_access(0, 16'h0011, 1'b0, 1'b1, 8'h99, rl, oe_e, rdv, ol, orl);
    n_vec++; if (port_out0 !== 8'h5A) begin n_err++; $display("FAIL io_miss_write: got %h want 5A", port_out0); end
    port_in = 8'h3C;
    exp_q.push_back(port_in);
    bus_access(1, 16'h4410, 1'b1, 1'b1, 8'h00, rl, oe_e, rdv, ol, orl);
    ev = exp_q.pop_front();
    n_vec++; if (rdv !== ev || oe_e !== 5 || rl !== 3) begin n_err++; $display("FAIL io_read_waits: got %h edge %0d low %0d want %h 5 3", rdv, oe_e, rl, ev); end
    exp_q.push_back(model[0][12'h010]);
    bus_access(0, 16'h0010, 1'b1, 1'b0, 8'h00, rl, oe_e, rdv, ol, orl);
    ev = exp_q.pop_front();
    n_vec++; if (rdv !== ev) begin n_err++; $display("FAIL io_ram_intact: got %h want %h", rdv, ev); end
`else
    bus_access(0, 16'h0010, 1'b1, 1'b1, 8'h00, rl, oe_e, rdv, ol, orl);
    n_vec++; if (oe_e !== 0 || rl !== 0) begin n_err++; $display("FAIL io_off_read: got edge %0d ready low %0d want 0 0", oe_e, rl); end
    bus_access(1, 16'h0010, 1'b1, 1'b1, 8'h00, rl, oe_e, rdv, ol, orl);
    n_vec++; if (oe_e !== 0 || rl !== 0) begin n_err++; $display("FAIL io_off_read_w3: got edge %0d ready low %0d want 0 0", oe_e, rl); end
    bus_access(0, 16'h0005, 1'b0, 1'b1, 8'hBB, rl, oe_e, rdv, ol, orl);
    exp_q.push_back(model[0][12'h005]);
    bus_access(0, 16'h0005, 1'b1, 1'b0, 8'h00, rl, oe_e, rdv, ol, orl);
    ev = exp_q.pop_front();
    n_vec++; if (rdv !== ev) begin n_err++; $display("FAIL io_off_no_write: got %h want %h", rdv, ev); end
`endif
  endtask

  task automatic test_back_to_back();
    int rl, oe_e; logic [7:0] rdv, ev, wd; logic ol, orl;
    logic [15:0] a;
    for (int i = 0; i < 8; i++) begin
      a  = 16'h0200 + 16'(i * 37);
      wd = 8'($urandom_range(0, 255));
      bus_access(i % 2, a, 1'b0, 1'b0, wd, rl, oe_e, rdv, ol, orl);
      model[i % 2][a[11:0]] = wd;
    end
    for (int i = 7; i >= 0; i--) begin
      a = 16'h0200 + 16'(i * 37);
      exp_q.push_back(model[i % 2][a[11:0]]);
      bus_access(i % 2, a, 1'b1, 1'b0, 8'h00, rl, oe_e, rdv, ol, orl);
      ev = exp_q.pop_front();
      n_vec++;
      if (rdv !== ev || oe_e !== ((i % 2 == 0) ? 2 : 5)) begin
        n_err++;
        $display("FAIL b2b_read %h dut%0d: got %h edge %0d want %h", a, i % 2, rdv, oe_e, ev);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_nowait();
    test_waits3();
    test_window();
    test_abort();
    test_reset_mid();
    test_illegal();
    test_io();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
